// File: rtl/microsequencer_pkg.sv
// rtl/microsequencer_pkg.sv - shared control-unit encodings for the microsequencer
package microsequencer_pkg;

    localparam int ADDR_W = 10;

    typedef enum logic [2:0] {
        NS_DECODE  = 3'd0,
        NS_INC     = 3'd1,
        NS_JUMP    = 3'd2,
        NS_BRANCH  = 3'd3,
        NS_WAIT    = 3'd4,
        NS_CALL    = 3'd5,
        NS_RET     = 3'd6,
        NS_RESTART = 3'd7
    } ns_mode_e;

    typedef enum logic [1:0] {
        SEL_MOC  = 2'd0,
        SEL_COND = 2'd1,
        SEL_ZF   = 2'd2,
        SEL_TRUE = 2'd3
    } sel_e;

endpackage

// File: rtl/microsequencer_condition_select_mux.sv
// rtl/microsequencer_condition_select_mux.sv - picks the branch condition and applies inversion
module condition_select_mux (
    input  logic [1:0] select,
    input  logic       inv,
    input  logic       moc,
    input  logic       cond,
    input  logic       zf,
    output logic       ct
);
    import microsequencer_pkg::*;

    logic raw;

    always_comb begin
        raw = 1'b1;
        case (sel_e'(select))
            SEL_MOC:  raw = moc;
            SEL_COND: raw = cond;
            SEL_ZF:   raw = zf;
            default:  raw = 1'b1;
        endcase
        ct = raw ^ inv;
    end

endmodule

// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - next-address generator feeding the microstore
module microsequencer #(
    parameter int ADDR_W      = microsequencer_pkg::ADDR_W,
    parameter int RESET_STATE = 0,
    parameter int FAULT_STATE = 1023,
    parameter int WAIT_LIMIT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        N,
    input  logic              inv,
    input  logic [1:0]        select,
    input  logic [ADDR_W-1:0] cr,
    input  logic [ADDR_W-1:0] enc_addr,
    input  logic              moc,
    input  logic              cond,
    input  logic              zf,
    output logic [ADDR_W-1:0] next_state,
    output logic [ADDR_W-1:0] state_q,
    output logic              mem_timeout,
    output logic              wait_active
);
    import microsequencer_pkg::*;

    localparam int                CNT_W      = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic              TIMEOUT_EN = (WAIT_LIMIT != 0);
    localparam logic [CNT_W-1:0]  LIMIT_M1   = CNT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);
    localparam logic [ADDR_W-1:0] RST_ADDR   = ADDR_W'(RESET_STATE);
    localparam logic [ADDR_W-1:0] FAULT_ADDR = ADDR_W'(FAULT_STATE);

    logic              ct;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] state_d;
    logic [ADDR_W-1:0] ret_d, ret_q;
    logic [CNT_W-1:0]  wait_cnt_d, wait_cnt_q;
    logic              waiting;
    logic              timeout;

    condition_select_mux u_cond_mux (
        .select (select),
        .inv    (inv),
        .moc    (moc),
        .cond   (cond),
        .zf     (zf),
        .ct     (ct)
    );

    always_comb begin
        inc        = state_q + ADDR_W'(1);
        waiting    = (ns_mode_e'(N) == NS_WAIT) && !ct;
        timeout    = TIMEOUT_EN && waiting && (wait_cnt_q == LIMIT_M1);
        next_state = RST_ADDR;
        ret_d      = ret_q;

        case (ns_mode_e'(N))
            NS_DECODE: next_state = enc_addr;
            NS_INC:    next_state = inc;
            NS_JUMP:   next_state = cr;
            NS_BRANCH: next_state = ct ? cr : inc;
            NS_WAIT:   next_state = ct ? inc : state_q;
            NS_CALL: begin
                next_state = ct ? cr : inc;
                if (ct) ret_d = inc;
            end
            NS_RET:    next_state = ret_q;
            default:   next_state = RST_ADDR;
        endcase

        // A stuck memory wait escapes to the fault handler instead of holding.
        if (timeout) next_state = FAULT_ADDR;

        wait_cnt_d = (waiting && !timeout) ? wait_cnt_q + CNT_W'(1) : '0;

        // Reset dominates the combinational outputs, not just the flops.
        if (reset) begin
            next_state = RST_ADDR;
            waiting    = 1'b0;
            timeout    = 1'b0;
        end

        wait_active = waiting;
        mem_timeout = timeout;
        state_d     = next_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RST_ADDR;
            ret_q      <= RST_ADDR + ADDR_W'(1);
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Next-state address generator for the microprogrammed control unit.
- Sits directly upstream of the microstore and takes its selection fields from the control register outputs (N, inv, select, cr). The loop is: control register -> microsequencer -> microstore -> control register.
- Drives the 10-bit next_state address into the microstore.
- Holds the sequencing state: last issued address, a one-level subroutine return register, and a memory-wait timeout counter.

Parameters:
- ADDR_W, 10, microstore address width.
- RESET_STATE, 0, address forced during reset and by N=7.
- FAULT_STATE, 1023, address issued when a memory wait times out.
- WAIT_LIMIT, 16, maximum cycles in an N=4 wait before a fault; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- N  input  3  next-state mode from the control register.
- inv  input  1  inverts the selected condition.
- select  input  2  condition select: 0=moc, 1=cond, 2=zf, 3=constant 1.
- cr  input  ADDR_W  target address field from the control register.
- enc_addr  input  ADDR_W  decode address from the instruction encoder.
- moc  input  1  memory operation complete.
- cond  input  1  branch condition from the condition tester.
- zf  input  1  zero flag from the flag register.
- next_state  output  ADDR_W  address to the microstore (combinational).
- state_q  output  ADDR_W  registered copy of the last issued next_state.
- mem_timeout  output  1  high for the cycle in which the wait timeout fires.
- wait_active  output  1  high while an N=4 wait holds the address.

Behaviour:
- ct = selected condition XOR inv. With select=3, ct = ~inv.
- inc = state_q + 1, modulo 2^ADDR_W, so 1023 wraps to 0.
- next_state decode on N:
  - 0: enc_addr.
  - 1: inc.
  - 2: cr.
  - 3: ct ? cr : inc.
  - 4: ct ? inc : state_q (hold and re-fetch).
  - 5: call, ct ? cr : inc. On a taken call, ret_q <= inc at the clock edge.
  - 6: ret_q.
  - 7: RESET_STATE.
- wait_active = (N==4) & ~ct.
- Wait counter wait_cnt (width ceil log2 WAIT_LIMIT, minimum 1):
  - Increments on each edge while wait_active.
  - Clears on any edge where wait_active is low.
- Timeout: if WAIT_LIMIT != 0, wait_active is high and wait_cnt == WAIT_LIMIT-1:
  - next_state = FAULT_STATE, overriding the hold.
  - mem_timeout = 1.
  - wait_cnt clears on that edge.
- On every rising edge, state_q <= next_state.
- Reset, asynchronous, immediate:
  - state_q = RESET_STATE, ret_q = RESET_STATE+1, wait_cnt = 0.
  - While reset is high, next_state is forced to RESET_STATE, and mem_timeout and wait_active are 0, regardless of the control inputs.
- Reset mid-wait: the counter clears, and after release sequencing restarts from RESET_STATE.
- Nested call: a second taken N=5 overwrites ret_q; there is no stack.
- N=6 with no prior call returns to ret_q = RESET_STATE+1.
- ct is evaluated combinationally in the same cycle. No added latency: a control word latched at edge k selects the address fetched for edge k+1.

Decomposition:
- Shared control-unit package holds:
  - ADDR_W.
  - The N mode encodings: NS_DECODE=0, NS_INC=1, NS_JUMP=2, NS_BRANCH=3, NS_WAIT=4, NS_CALL=5, NS_RET=6, NS_RESTART=7.
  - The select encodings: SEL_MOC, SEL_COND, SEL_ZF, SEL_TRUE.
- One natural sub-module, condition_select_mux: select/inv -> ct. It is combinational.
- The incrementer, registers and timeout counter stay in microsequencer.

Test Plan:
- Reset held with N=2, cr=100 -> next_state=0. Release reset, N=1 -> next_state=1, then 2, 3 on successive edges.
- Branch: state_q=20, N=3, cr=300, select=1:
  - cond=1, inv=0 -> next_state=300.
  - cond=1, inv=1 -> next_state=21.
  - select=3, inv=0 -> 300.
- Wait: state_q=40, N=4, select=0, moc=0 for 3 cycles -> next_state stays 40 and wait_active=1. Then moc=1 -> next_state=41, wait_active=0, counter cleared.
- Timeout: WAIT_LIMIT=16, N=4, moc=0 held -> on the 16th cycle next_state=1023 and mem_timeout=1 for one cycle; then state_q=1023.
- Call/return: state_q=50, N=5, select=3, cr=500 -> next_state=500, ret_q=51. Later N=6 -> next_state=51. Wrap check: state_q=1023, N=1 -> next_state=0.
- Asynchronous reset asserted mid-wait (wait_cnt=7) between clock edges -> state_q=0 and next_state=0 immediately. After release, a fresh wait needs the full 16 cycles to time out.
